// File: rtl/input_port_buffer.sv
// Per-port ingress FIFO: buffers link flits first-word-fall-through until outputPort
// accepts the head (portBlock low). Arrivals while full are dropped and flagged stickily.
module input_port_buffer #(
  parameter int dataWidth = 14,
  parameter int depth     = 4,
  parameter int ptrWidth  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [dataWidth-1:0] inData,
  output logic                 inReady,
  output logic [dataWidth-1:0] outData,
  input  logic                 portBlock,
  output logic [ptrWidth:0]    count,
  output logic                 overflow
);

  localparam logic [ptrWidth:0]   DEPTH_C = (ptrWidth + 1)'(depth);
  localparam logic [ptrWidth:0]   CNT_ONE = (ptrWidth + 1)'(1'b1);
  localparam logic [ptrWidth-1:0] PTR_ONE = ptrWidth'(1'b1);

  logic [dataWidth-1:0] r_mem [depth];
  logic [ptrWidth-1:0]  r_wr_ptr;
  logic [ptrWidth-1:0]  r_rd_ptr;
  logic [ptrWidth:0]    r_count;
  logic                 r_overflow;

  logic w_full;
  logic w_empty;
  logic w_valid_in;
  logic w_push;
  logic w_pop;

  // Handshake decode; inReady depends only on registered occupancy, never on portBlock.
  always_comb begin
    w_full     = (r_count == DEPTH_C);
    w_empty    = (r_count == {(ptrWidth + 1){1'b0}});
    w_valid_in = inData[dataWidth-1];
    w_push     = w_valid_in & ~w_full;
    w_pop      = ~w_empty & ~portBlock;
  end

  // Storage writes; a popped slot keeps its stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= {dataWidth{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= inData;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= {ptrWidth{1'b0}};
      r_rd_ptr   <= {ptrWidth{1'b0}};
      r_count    <= {(ptrWidth + 1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_valid_in & w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  // Zero-cycle head: the oldest flit is visible as soon as it is stored.
  always_comb begin
    inReady  = ~w_full;
    count    = r_count;
    overflow = r_overflow;
    if (!w_empty) begin
      outData = r_mem[r_rd_ptr];
    end else begin
      outData = {dataWidth{1'b0}};
    end
  end

endmodule
